// File: rtl/ahb_stream_rx.sv
// AHB-Lite slave that receives a byte stream as 32-bit words into a FIFO.
// A small register window at BASE_ADDR controls the transfer (START,
// FILE_SIZE, DATA, STOP, STATUS). DATA writes stall the bus while the FIFO
// is full; STOP stalls until the consumer has drained everything.
module ahb_stream_rx #(
   parameter logic [31:0] BASE_ADDR = 32'd1000,
   parameter int          DEPTH     = 8,
   parameter int          SIZE_W    = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [31:0]       HWDATA,
   output logic [31:0]       HRDATA,
   output logic              HREADY,
   output logic              HRESP,
   output logic              start,
   output logic              stop,
   output logic [SIZE_W-1:0] file_size,
   input  logic              rd_en,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   output logic              done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      IDLE, ACCESS, WAIT_FULL, WAIT_DRAIN, ERR1, ERR2
   } state_t;

   typedef enum logic [2:0] {
      OP_NONE, OP_START, OP_FSIZE_WR, OP_FSIZE_RD,
      OP_DATA, OP_STOP, OP_STATUS, OP_ERROR
   } op_t;

   state_t            state_q, state_d;
   op_t               op_q, addr_op;
   logic              hready_c, accept;
   logic              push, pop, flush, fsize_wr;
   logic              full, empty;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [31:0]       mem [DEPTH];
   logic [SIZE_W-1:0] bytes_left;
   logic              pushed_q;
   logic [7:0]        count8;
   logic              unused_hsize;

   // Map an address-phase access onto the operation its data phase performs.
   function automatic op_t decode_op(input logic [31:0] addr, input logic write);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      if ((addr < BASE_ADDR) || (off > 32'd15))
         return OP_NONE;
      case (off[3:0])
         4'd1:    return write ? OP_START    : OP_ERROR;
         4'd2:    return write ? OP_FSIZE_WR : OP_FSIZE_RD;
         4'd3:    return write ? OP_DATA     : OP_ERROR;
         4'd4:    return write ? OP_STOP     : OP_ERROR;
         4'd5:    return write ? OP_ERROR    : OP_STATUS;
         default: return OP_ERROR;
      endcase
   endfunction

   // Each pushed word accounts for up to four bytes; never underflow.
   function automatic logic [SIZE_W-1:0] sat_dec4(input logic [SIZE_W-1:0] v);
      if (v >= SIZE_W'(4))
         return v - SIZE_W'(4);
      return '0;
   endfunction

   assign addr_op      = decode_op(HADDR, HWRITE);
   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign rd_valid     = ~empty;
   assign rd_data      = mem[rd_ptr];
   assign done         = pushed_q & (bytes_left == '0);
   assign count8       = 8'(count);
   assign HREADY       = hready_c;
   assign unused_hsize = ^HSIZE;

   // Data-phase outputs, FIFO occupancy update and next-state selection.
   always_comb begin
      state_d   = state_q;
      hready_c  = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = '0;
      start     = 1'b0;
      stop      = 1'b0;
      push      = 1'b0;
      flush     = 1'b0;
      fsize_wr  = 1'b0;
      count_nxt = count;
      accept    = 1'b0;

      case (state_q)
         ACCESS: begin
            case (op_q)
               OP_START:    begin start = 1'b1; flush = 1'b1; end
               OP_FSIZE_WR: fsize_wr = 1'b1;
               OP_FSIZE_RD: HRDATA = 32'(file_size);
               OP_DATA:     push = 1'b1;
               OP_STOP:     stop = 1'b1;
               OP_STATUS:   HRDATA = {16'b0, count8, 5'b0, done, full, empty};
               default:     ;
            endcase
         end
         WAIT_FULL: begin
            // A same-cycle pop frees the slot the held word needs.
            hready_c = ~full | rd_en;
            push     = hready_c;
         end
         WAIT_DRAIN: begin
            hready_c = empty;
            stop     = empty;
         end
         ERR1: begin
            hready_c = 1'b0;
            HRESP    = 1'b1;
         end
         ERR2:    HRESP = 1'b1;
         default: ;
      endcase

      pop = rd_en & ~empty;
      if (flush)
         count_nxt = '0;
      else
         count_nxt = count + CNT_W'(push) - CNT_W'(pop);

      accept = HSEL & HTRANS[1] & hready_c;

      if (hready_c) begin
         if (accept) begin
            case (addr_op)
               OP_ERROR: state_d = ERR1;
               // Decide the stall up front from the occupancy the data phase will see.
               OP_DATA:  state_d = (count_nxt == FULL_CNT) ? WAIT_FULL : ACCESS;
               OP_STOP:  state_d = (count_nxt == '0) ? ACCESS : WAIT_DRAIN;
               default:  state_d = ACCESS;
            endcase
         end else begin
            state_d = IDLE;
         end
      end else if (state_q == ERR1) begin
         state_d = ERR2;
      end
   end

   // Data-phase state and the operation captured in the address phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         op_q    <= OP_NONE;
      end else begin
         state_q <= state_d;
         if (hready_c)
            op_q <= accept ? addr_op : OP_NONE;
      end
   end

   // Transfer bookkeeping: programmed size, bytes remaining, push-since-START flag.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         file_size  <= '0;
         bytes_left <= '0;
         pushed_q   <= 1'b0;
      end else if (flush) begin
         bytes_left <= file_size;
         pushed_q   <= 1'b0;
      end else if (fsize_wr) begin
         file_size  <= HWDATA[SIZE_W-1:0];
         bytes_left <= HWDATA[SIZE_W-1:0];
      end else if (push) begin
         bytes_left <= sat_dec4(bytes_left);
         pushed_q   <= 1'b1;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // FIFO storage; contents are meaningless until counted in.
   always_ff @(posedge HCLK) begin
      if (push)
         mem[wr_ptr] <= HWDATA;
   end

endmodule

// File: tb/tb_ahb_stream_rx.sv
// Self-checking bench for ahb_stream_rx: register-access vector table, then
// hand-written sequences for streaming, back-pressure, drain-on-STOP and reset.
module tb_ahb_stream_rx;

   localparam logic [31:0] B        = 32'd1000;
   localparam logic [31:0] A_START  = B + 32'd1;
   localparam logic [31:0] A_FSIZE  = B + 32'd2;
   localparam logic [31:0] A_DATA   = B + 32'd3;
   localparam logic [31:0] A_STOP   = B + 32'd4;
   localparam logic [31:0] A_STATUS = B + 32'd5;
   localparam int          NVEC     = 18;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic        start;
   logic        stop;
   logic [15:0] file_size;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        done;

   ahb_stream_rx #(.BASE_ADDR(B), .DEPTH(8), .SIZE_W(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .start(start),
      .stop(stop), .file_size(file_size), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .done(done)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t        vt [NVEC];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb_q [$];

   logic [31:0] r_rdata;
   int          r_nwait, r_nstart, r_nstop;
   logic        r_resp0, r_resp1, r_stopd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge with rd_en high: the head word must match the scoreboard.
   task automatic pop_check(input string name);
      logic [31:0] exp;
      chk({name, "_valid"}, 32'(rd_valid), 32'h1);
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_sb: got pop with empty scoreboard, expected a queued word", name);
      end else begin
         exp = sb_q.pop_front();
         chk({name, "_data"}, rd_data, exp);
      end
   endtask

   task automatic pop_words(input int n);
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         @(negedge HCLK);
         pop_check("pop");
         @(posedge HCLK);
         #1;
         rd_en = 1'b0;
      end
   endtask

   // One non-pipelined AHB transfer; rd_en is raised for rd_n data-phase cycles from rd_at.
   task automatic go(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input int rd_at, input int rd_n);
      int cyc;
      bit finished;
      r_nwait = 0; r_nstart = 0; r_nstop = 0; r_resp0 = 1'b0; r_resp1 = 1'b0;
      r_rdata = '0; r_stopd = 1'b0; finished = 1'b0; cyc = 0;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HWDATA = '0;
      if (wr && addr == A_DATA)  sb_q.push_back(wd);
      if (wr && addr == A_START) sb_q.delete();
      @(negedge HCLK);
      r_nstart += start ? 1 : 0;
      r_nstop  += stop ? 1 : 0;
      @(posedge HCLK);
      #1;
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HWDATA = wd;
      while (!finished && cyc < 64) begin
         rd_en = (cyc >= rd_at) && (cyc < rd_at + rd_n);
         @(negedge HCLK);
         if (rd_en) pop_check("xfer_pop");
         if (cyc == 0) r_resp0 = HRESP;
         r_resp1 = HRESP;
         r_rdata = HRDATA;
         r_nstart += start ? 1 : 0;
         r_nstop  += stop ? 1 : 0;
         if (HREADY) begin
            finished = 1'b1;
            r_stopd  = stop;
         end else begin
            r_nwait++;
         end
         @(posedge HCLK);
         #1;
         cyc++;
      end
      rd_en = 1'b0;
      HWDATA = '0;
      if (!finished) begin
         n_checks++;
         n_errors++;
         $display("FAIL xfer_timeout: got no HREADY in 64 cycles at addr 0x%08h, expected completion", addr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{A_FSIZE,      1'b1, 32'd10,        32'd0,       1'b0};
      vt[1]  = '{A_FSIZE,      1'b0, 32'd0,         32'd10,      1'b0};
      vt[2]  = '{A_STATUS,     1'b0, 32'd0,         32'h1,       1'b0};
      vt[3]  = '{A_STATUS,     1'b1, 32'hFFFF,      32'd0,       1'b1};
      vt[4]  = '{A_FSIZE,      1'b0, 32'd0,         32'd10,      1'b0};
      vt[5]  = '{B + 32'd9,    1'b0, 32'd0,         32'd0,       1'b1};
      vt[6]  = '{A_START,      1'b0, 32'd0,         32'd0,       1'b1};
      vt[7]  = '{A_DATA,       1'b0, 32'd0,         32'd0,       1'b1};
      vt[8]  = '{A_STOP,       1'b0, 32'd0,         32'd0,       1'b1};
      vt[9]  = '{B,            1'b1, 32'd7,         32'd0,       1'b1};
      vt[10] = '{B + 32'd15,   1'b0, 32'd0,         32'd0,       1'b1};
      vt[11] = '{B + 32'd16,   1'b0, 32'd0,         32'd0,       1'b0};
      vt[12] = '{B - 32'd1,    1'b1, 32'h55,        32'd0,       1'b0};
      vt[13] = '{A_FSIZE,      1'b1, 32'hABCD1234,  32'd0,       1'b0};
      vt[14] = '{A_FSIZE,      1'b0, 32'd0,         32'h1234,    1'b0};
      vt[15] = '{A_FSIZE,      1'b1, 32'd10,        32'd0,       1'b0};
      vt[16] = '{B + 32'd18,   1'b1, 32'd7,         32'd0,       1'b0};
      vt[17] = '{A_FSIZE,      1'b0, 32'd0,         32'd10,      1'b0};

      HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b010; HWDATA = '0; rd_en = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_hready",   32'(HREADY),    32'h1);
      chk("rst_hresp",    32'(HRESP),     32'h0);
      chk("rst_hrdata",   HRDATA,         32'h0);
      chk("rst_start",    32'(start),     32'h0);
      chk("rst_stop",     32'(stop),      32'h0);
      chk("rst_done",     32'(done),      32'h0);
      chk("rst_filesize", 32'(file_size), 32'h0);
      chk("rst_rdvalid",  32'(rd_valid),  32'h0);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      // Register map, error responses and out-of-window accesses.
      for (int i = 0; i < NVEC; i++) begin
         go(vt[i].addr, vt[i].wr, vt[i].wd, -1, 0);
         if (vt[i].exp_err) begin
            chk($sformatf("vec%0d_err_wait", i), 32'(r_nwait), 32'd1);
            chk($sformatf("vec%0d_err_resp1", i), 32'(r_resp0), 32'h1);
            chk($sformatf("vec%0d_err_resp2", i), 32'(r_resp1), 32'h1);
         end else begin
            chk($sformatf("vec%0d_wait", i), 32'(r_nwait), 32'd0);
            chk($sformatf("vec%0d_resp", i), 32'(r_resp1), 32'h0);
         end
         chk($sformatf("vec%0d_rdata", i), r_rdata, vt[i].exp_rd);
      end
      chk("file_size_port", 32'(file_size), 32'd10);

      // Stream of ten bytes as three words.
      go(A_FSIZE, 1'b1, 32'd10, -1, 0);
      go(A_START, 1'b1, 32'd0, -1, 0);
      chk("start_pulses", 32'(r_nstart), 32'd1);
      chk("start_low_after", 32'(start), 32'h0);
      chk("bytes_left_reload", 32'(dut.bytes_left), 32'd10);
      go(A_DATA, 1'b1, 32'hA5A50001, -1, 0);
      chk("d1_wait", 32'(r_nwait), 32'd0);
      chk("d1_bytes_left", 32'(dut.bytes_left), 32'd6);
      chk("d1_rd_valid", 32'(rd_valid), 32'h1);
      chk("d1_done", 32'(done), 32'h0);
      go(A_DATA, 1'b1, 32'hA5A50002, -1, 0);
      chk("d2_bytes_left", 32'(dut.bytes_left), 32'd2);
      chk("d2_done", 32'(done), 32'h0);
      go(A_DATA, 1'b1, 32'hA5A50003, -1, 0);
      chk("d3_bytes_left", 32'(dut.bytes_left), 32'd0);
      chk("d3_done", 32'(done), 32'h1);
      pop_words(3);
      chk("drained_rd_valid", 32'(rd_valid), 32'h0);
      chk("done_level", 32'(done), 32'h1);

      // Fill to DEPTH, then a stalled ninth write released by one pop.
      go(A_FSIZE, 1'b1, 32'd100, -1, 0);
      go(A_START, 1'b1, 32'd0, -1, 0);
      go(A_STATUS, 1'b0, 32'd0, -1, 0);
      chk("status_after_start", r_rdata, 32'h1);
      for (int i = 0; i < 8; i++) begin
         go(A_DATA, 1'b1, 32'h10000000 + 32'(i), -1, 0);
         chk($sformatf("fill%0d_wait", i), 32'(r_nwait), 32'd0);
      end
      go(A_STATUS, 1'b0, 32'd0, -1, 0);
      chk("status_full", r_rdata, 32'h00000802);
      go(A_DATA, 1'b1, 32'h10000008, 2, 1);
      chk("ninth_wait", 32'(r_nwait), 32'd2);
      chk("ninth_resp", 32'(r_resp1), 32'h0);
      go(A_STATUS, 1'b0, 32'd0, -1, 0);
      chk("status_after_ninth", r_rdata, 32'h00000802);

      // Full FIFO, push and pop in the same cycle: no wait state.
      go(A_DATA, 1'b1, 32'h10000009, 0, 1);
      chk("pushpop_wait", 32'(r_nwait), 32'd0);
      go(A_STATUS, 1'b0, 32'd0, -1, 0);
      chk("status_pushpop", r_rdata, 32'h00000802);
      pop_words(8);
      chk("wrap_drained", 32'(rd_valid), 32'h0);

      // STOP waits for the consumer to drain two buffered words.
      go(A_START, 1'b1, 32'd0, -1, 0);
      go(A_DATA, 1'b1, 32'hC0DE0001, -1, 0);
      go(A_DATA, 1'b1, 32'hC0DE0002, -1, 0);
      go(A_STOP, 1'b1, 32'd0, 0, 2);
      chk("stop_wait", 32'(r_nwait), 32'd2);
      chk("stop_pulses", 32'(r_nstop), 32'd1);
      chk("stop_at_ready", 32'(r_stopd), 32'h1);
      chk("stop_rd_valid", 32'(rd_valid), 32'h0);
      go(A_STOP, 1'b1, 32'd0, -1, 0);
      chk("stop_empty_wait", 32'(r_nwait), 32'd0);
      chk("stop_empty_pulse", 32'(r_nstop), 32'd1);

      // Reset asserted while a DATA write is stalled on a full FIFO.
      go(A_FSIZE, 1'b1, 32'd10, -1, 0);
      go(A_START, 1'b1, 32'd0, -1, 0);
      for (int i = 0; i < 8; i++) go(A_DATA, 1'b1, 32'h20000000 + 32'(i), -1, 0);
      chk("pre_abort_done", 32'(done), 32'h1);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_DATA; HWRITE = 1'b1;
      @(posedge HCLK);
      #1;
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HWDATA = 32'hDEADBEEF;
      @(negedge HCLK);
      chk("abort_stall", 32'(HREADY), 32'h0);
      #2;
      HRESETn = 1'b0;
      #1;
      chk("arst_hready",   32'(HREADY),    32'h1);
      chk("arst_hresp",    32'(HRESP),     32'h0);
      chk("arst_hrdata",   HRDATA,         32'h0);
      chk("arst_start",    32'(start),     32'h0);
      chk("arst_stop",     32'(stop),      32'h0);
      chk("arst_done",     32'(done),      32'h0);
      chk("arst_filesize", 32'(file_size), 32'h0);
      chk("arst_rdvalid",  32'(rd_valid),  32'h0);
      HWDATA = '0;
      sb_q.delete();
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("post_rst_hready", 32'(HREADY), 32'h1);
      @(posedge HCLK);
      #1;
      go(A_STATUS, 1'b0, 32'd0, -1, 0);
      chk("post_rst_status", r_rdata, 32'h1);
      go(A_FSIZE, 1'b0, 32'd0, -1, 0);
      chk("post_rst_fsize", r_rdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb_stream_rx.md
AHB_STREAM_RX -- requirements
Module: ahb_stream_rx

Interface
- REQ-001 Parameter BASE_ADDR, default 32'd1000, base of the register map.
- REQ-002 Parameter DEPTH, default 8, data FIFO depth in 32-bit words; power of two, >= 2.
- REQ-003 Parameter SIZE_W, default 16, width of the file-size and bytes-left registers.
- REQ-004 HCLK  in  1  clock; all state updates on the rising edge.
- REQ-005 HRESETn  in  1  reset, asynchronous, active-low.
- REQ-006 HSEL  in  1  slave select.
- REQ-007 HADDR  in  32  byte address, sampled in the address phase.
- REQ-008 HTRANS  in  2  transfer type; NONSEQ or SEQ (HTRANS[1]=1) is active.
- REQ-009 HWRITE  in  1  1 = write.
- REQ-010 HSIZE  in  3  accepted but ignored; all accesses are treated as 32-bit.
- REQ-011 HWDATA  in  32  write data, valid in the data phase.
- REQ-012 HRDATA  out  32  read data, valid in the data phase.
- REQ-013 HREADY  out  1  transfer-done / wait-state control.
- REQ-014 HRESP  out  1  0 = OKAY, 1 = ERROR.
- REQ-015 start  out  1  one-cycle pulse on a START write.
- REQ-016 stop  out  1  one-cycle pulse when a STOP write completes.
- REQ-017 file_size  out  SIZE_W  last programmed file size in bytes.
- REQ-018 rd_en  in  1  consumer pop request.
- REQ-019 rd_data  out  32  FIFO head word, valid while rd_valid=1.
- REQ-020 rd_valid  out  1  FIFO not empty.
- REQ-021 done  out  1  level; bytes_left==0 after at least one DATA push since START.

Function
- REQ-022 Register map (offset from BASE_ADDR):
  - +1 START: W.
  - +2 FILE_SIZE: R/W; HWDATA[SIZE_W-1:0].
  - +3 DATA: W.
  - +4 STOP: W.
  - +5 STATUS: R; {16'b0, count[7:0], 5'b0, done, full, empty}.
- REQ-023 Address-phase qualifier: HSEL & HTRANS[1] & HREADY. When it is true, the decoded address and HWRITE are registered; the data-phase action occurs in the following cycle(s).
- REQ-024 START data phase:
  - pulse start for 1 cycle;
  - flush the FIFO (count=0);
  - clear done;
  - reload bytes_left from file_size.
- REQ-025 FILE_SIZE write: file_size and bytes_left take HWDATA[SIZE_W-1:0] at the end of the data phase. A FILE_SIZE read returns file_size zero-extended.
- REQ-026 DATA write, FIFO not full (or rd_en asserted in the same cycle):
  - push HWDATA;
  - HREADY=1;
  - bytes_left decrements by min(4, bytes_left), saturating at 0.
- REQ-027 DATA write, FIFO full and rd_en=0: drive HREADY=0 and hold the data phase. The push occurs in the first cycle in which space exists, or in which rd_en=1; HWDATA is held by the master throughout.
- REQ-028 Push and pop in the same cycle: count is unchanged and no wait state is inserted.
- REQ-029 rd_en while empty is ignored. Pointers wrap modulo DEPTH. count range is 0..DEPTH.
- REQ-030 STOP write: drive HREADY=0 until the FIFO is empty, then complete the transfer with HREADY=1 and pulse stop in that same cycle.
- REQ-031 Error response for an unmapped offset within BASE_ADDR..BASE_ADDR+15, a write to STATUS, or a read of a W-only register:
  - two-cycle ERROR;
  - cycle 1: HRESP=1, HREADY=0;
  - cycle 2: HRESP=1, HREADY=1;
  - no side effects.
- REQ-032 Addresses outside BASE_ADDR..BASE_ADDR+15 while HSEL=1 get an OKAY response with no side effect; HRDATA=0.
- REQ-033 Data-phase FSM:
  - states IDLE, ACCESS, WAIT_FULL, WAIT_DRAIN, ERR1, ERR2;
  - HREADY=0 only in WAIT_FULL, WAIT_DRAIN and ERR1;
  - a new address phase is accepted only from a cycle with HREADY=1.
- REQ-034 HRDATA=0 outside read data phases. rd_data is the registered FIFO head and shows no extra latency: a push into an empty FIFO gives rd_valid=1 in the next cycle.

Reset
- REQ-035 With HRESETn=0, asynchronously:
  - FSM=IDLE;
  - HREADY=1, HRESP=0, HRDATA=0;
  - start=0, stop=0, done=0;
  - file_size=0, bytes_left=0;
  - FIFO pointers and count 0, rd_valid=0.
- REQ-036 Reset mid-transfer (including WAIT_FULL or WAIT_DRAIN) abandons the transfer. FIFO contents are discarded, and the first post-reset cycle shows HREADY=1.

Verification
- REQ-037 Write FILE_SIZE=10, START, then three DATA words -> start pulses once. bytes_left steps 6, 2, 0. done=1 after the 3rd push. rd_valid=1 one cycle after the 1st push.
- REQ-038 DEPTH=8, rd_en=0, nine DATA writes -> the 9th holds HREADY=0. One rd_en pulse completes it with HREADY=1 and count=8.
- REQ-039 FIFO full with DATA write and rd_en=1 in the same data-phase cycle -> no wait state, count stays 8.
- REQ-040 Two words buffered, STOP written -> HREADY=0 until two rd_en pops. stop pulses in the cycle of HREADY=1.
- REQ-041 Write to STATUS (+5), then read of offset +9 -> each gets a two-cycle ERROR (HRESP=1 both cycles, HREADY 0 then 1). Registers are unchanged.
- REQ-042 Assert HRESETn=0 during WAIT_FULL -> all outputs at reset values immediately. After release, a STATUS read returns empty=1, count=0.
